// File: rtl/switch_pkg.sv
// Shared types and constants for the parameterised packet switch.
package switch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_SA,
    HDR_LEN,
    PAYLOAD,
    PARITY,
    DROP
  } in_state_e;

  localparam int DEF_NPORTS = 4;
  localparam int DEF_DW     = 8;
  localparam int DEF_DEPTH  = 256;
  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/switch_port_fifo.sv
// One output-port FIFO: speculative writes, commit/rollback of the write
// pointer, and registered reads limited to committed bytes.
module switch_port_fifo
  import switch_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          commit,
  input  logic          rollback,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_V = {1'b1, {AW{1'b0}}};

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cmt_ptr_q, cmt_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   used;
  logic [AW:0]   committed;
  logic          do_wr;
  logic          do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    used      = wr_ptr_q - rd_ptr_q;
    committed = cmt_ptr_q - rd_ptr_q;
    full      = (used == FULL_V);
    ready     = (committed != '0);
    do_wr     = wr_en && !full && !rollback;
    do_rd     = rd_en && ready;

    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;

    if (rollback)   wr_ptr_d = cmt_ptr_q;
    else if (do_wr) wr_ptr_d = wr_ptr_q + ONE;
    if (commit)     cmt_ptr_d = wr_ptr_q;
    if (do_rd) begin
      rd_ptr_d  = rd_ptr_q + ONE;
      rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/param_switch.sv
// Packet switch: parses DA/SA/LEN/payload/parity, routes by address register
// match into per-port FIFOs, commits good packets and drops bad ones.
module param_switch
  import switch_pkg::*;
#(
  parameter int NPORTS = DEF_NPORTS,
  parameter int DW     = DEF_DW,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_status,
  input  logic [DW-1:0]            data,
  output logic [NPORTS*DW-1:0]     port,
  output logic [NPORTS-1:0]        ready,
  input  logic [NPORTS-1:0]        read,
  input  logic                     mem_en,
  input  logic                     mem_rd_wr,
  input  logic [$clog2(NPORTS)-1:0] mem_add,
  input  logic [DW-1:0]            mem_data,
  output logic [DW-1:0]            mem_rdata,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  localparam int SW = $clog2(NPORTS);

  in_state_e             state_q, state_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [DW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         par_q, par_d;
  logic                  par_done_q, par_done_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DW-1:0]         addr_reg_q [NPORTS];
  logic [DW-1:0]         addr_reg_d [NPORTS];
  logic [DW-1:0]         mem_rdata_q, mem_rdata_d;

  logic                  match;
  logic [SW-1:0]         match_idx;
  logic [SW-1:0]         wr_sel;
  logic                  cur_full;
  logic [DW-1:0]         nxt_par;
  logic                  wr, commit, rollback, drop_inc;
  logic [NPORTS-1:0]     fifo_wr, fifo_commit, fifo_rollback, fifo_full;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (data == addr_reg_q[i]) begin
        match     = 1'b1;
        match_idx = SW'(i);
      end
    end
    wr_sel   = (state_q == IDLE) ? match_idx : sel_q;
    cur_full = fifo_full[wr_sel];
    nxt_par  = par_q ^ data;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    par_done_d = par_done_q;
    wr         = 1'b0;
    commit     = 1'b0;
    rollback   = 1'b0;
    drop_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_status) begin
          if (!match || cur_full) begin
            drop_inc = 1'b1;
            state_d  = DROP;
          end else begin
            wr      = 1'b1;
            sel_d   = match_idx;
            par_d   = data;
            state_d = HDR_SA;
          end
        end
      end
      HDR_SA, HDR_LEN, PAYLOAD: begin
        if (!data_status) begin
          rollback = 1'b1;
          drop_inc = 1'b1;
          state_d  = IDLE;
        end else if (cur_full) begin
          rollback = 1'b1;
          drop_inc = 1'b1;
          state_d  = DROP;
        end else begin
          wr    = 1'b1;
          par_d = nxt_par;
          if (state_q == HDR_SA) begin
            state_d = HDR_LEN;
          end else if (state_q == HDR_LEN) begin
            cnt_d   = data;
            state_d = (data == '0) ? PARITY : PAYLOAD;
          end else begin
            cnt_d = cnt_q - DW'(1);
            if (cnt_q == DW'(1)) state_d = PARITY;
          end
        end
      end
      PARITY: begin
        // par_done marks the parity byte as stored; the next cycle must be idle.
        if (!par_done_q) begin
          if (!data_status) begin
            rollback = 1'b1;
            drop_inc = 1'b1;
            state_d  = IDLE;
          end else if (cur_full || nxt_par != '0) begin
            rollback = 1'b1;
            drop_inc = 1'b1;
            state_d  = DROP;
          end else begin
            wr         = 1'b1;
            par_done_d = 1'b1;
          end
        end else begin
          par_done_d = 1'b0;
          if (!data_status) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            rollback = 1'b1;
            drop_inc = 1'b1;
            state_d  = DROP;
          end
        end
      end
      DROP: begin
        if (!data_status) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);

    addr_reg_d  = addr_reg_q;
    mem_rdata_d = mem_rdata_q;
    if (mem_en && int'(mem_add) < NPORTS) begin
      if (mem_rd_wr) addr_reg_d[mem_add] = mem_data;
      else           mem_rdata_d = addr_reg_q[mem_add];
    end

    for (int i = 0; i < NPORTS; i++) begin
      fifo_wr[i]       = wr && (wr_sel == SW'(i));
      fifo_commit[i]   = commit && (sel_q == SW'(i));
      fifo_rollback[i] = rollback && (sel_q == SW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      par_q       <= '0;
      par_done_q  <= 1'b0;
      drop_cnt_q  <= '0;
      mem_rdata_q <= '0;
      for (int i = 0; i < NPORTS; i++) addr_reg_q[i] <= DW'(i);
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      par_done_q  <= par_done_d;
      drop_cnt_q  <= drop_cnt_d;
      mem_rdata_q <= mem_rdata_d;
      addr_reg_q  <= addr_reg_d;
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    switch_port_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (fifo_wr[g]),
      .wr_data  (data),
      .commit   (fifo_commit[g]),
      .rollback (fifo_rollback[g]),
      .rd_en    (read[g]),
      .rd_data  (port[g*DW +: DW]),
      .full     (fifo_full[g]),
      .ready    (ready[g])
    );
  end

  assign mem_rdata  = mem_rdata_q;
  assign drop_count = drop_cnt_q;

endmodule
